query_initiator: RTL and testbench

- Initiating end of the query interface served by the slot/query responder block.
- On each enabled slot tick, issues a burst of QUERIES_PER_SLOT queries, one at a time, with consecutive seed values.
- Waits for each end pulse, measures the response latency in clocks, reports every result, and tracks the maximum-latency seed.
- Sits between the slot-tick source and the query responder, alongside the test harness.

---
 rtl/query_initiator.sv | 167 ++++++++++++++++
 tb/tb_query_initiator.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/query_initiator.sv
// rtl/query_initiator.sv - slot-driven query burst initiator with latency measurement
//
// Purpose:
//   On each enabled slot tick, issues a burst of QUERIES_PER_SLOT queries to the
//   responder, one at a time, using consecutive non-zero seed values. It measures
//   each query's response latency in clocks, reports every result and tracks the
//   seed with the largest non-timeout latency.
//
// Ports:
//   iClk, iRsn          clock, synchronous active-high reset
//   iEnable             allows bursts to start and to continue
//   iSlotTick           slot tick pulse
//   iSeedLoadEn, iSeed  seed load (IDLE only, zero loads as 1)
//   iClrMax             clear maximum tracking
//   oQueryDataEn/Data   one-cycle query issue strobe and value
//   iQueryEnd           end pulse from the responder
//   oResult*            one-cycle result strobe with held seed/steps/timeout
//   oMaxSeed/oMaxSteps  seed with the largest non-timeout step count
//   oBusy               initiator is not idle
//   oSlotOverrun        tick arrived while busy (registered pulse)

module query_initiator #(
    parameter int BW_QUERY_DATA    = 4,
    parameter int BW_STEP          = 16,
    parameter int QUERIES_PER_SLOT = 4,
    parameter int TIMEOUT          = 64
) (
    input  logic                     iClk,
    input  logic                     iRsn,
    input  logic                     iEnable,
    input  logic                     iSlotTick,
    input  logic                     iSeedLoadEn,
    input  logic [BW_QUERY_DATA-1:0] iSeed,
    input  logic                     iClrMax,
    output logic                     oQueryDataEn,
    output logic [BW_QUERY_DATA-1:0] oQueryData,
    input  logic                     iQueryEnd,
    output logic                     oResultValid,
    output logic [BW_QUERY_DATA-1:0] oResultSeed,
    output logic [BW_STEP-1:0]       oResultSteps,
    output logic                     oResultTimeout,
    output logic [BW_QUERY_DATA-1:0] oMaxSeed,
    output logic [BW_STEP-1:0]       oMaxSteps,
    output logic                     oBusy,
    output logic                     oSlotOverrun
);

    // The query counter only needs to reach QUERIES_PER_SLOT-1: the last
    // query is detected before the increment.
    localparam int QCW = (QUERIES_PER_SLOT > 1) ? $clog2(QUERIES_PER_SLOT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_REPORT
    } state_t;

    state_t                   state;
    logic [BW_QUERY_DATA-1:0] seed;
    logic [BW_QUERY_DATA-1:0] loadSeed;
    logic [BW_QUERY_DATA-1:0] nextSeed;
    logic [QCW-1:0]           queryCnt;
    logic [BW_STEP-1:0]       stepCnt;
    logic                     lastQuery;

    // A zero query never ends, so zero is never allowed into the seed register.
    always_comb begin
        loadSeed  = (iSeed == '0) ? BW_QUERY_DATA'(1) : iSeed;
        nextSeed  = (&seed) ? BW_QUERY_DATA'(1) : seed + BW_QUERY_DATA'(1);
        lastQuery = (queryCnt == QCW'(QUERIES_PER_SLOT - 1));
    end

    assign oBusy = (state != ST_IDLE);

    always_ff @(posedge iClk) begin
        if (iRsn) begin
            state          <= ST_IDLE;
            seed           <= BW_QUERY_DATA'(1);
            queryCnt       <= '0;
            stepCnt        <= '0;
            oQueryDataEn   <= 1'b0;
            oQueryData     <= '0;
            oResultValid   <= 1'b0;
            oResultSeed    <= '0;
            oResultSteps   <= '0;
            oResultTimeout <= 1'b0;
            oMaxSeed       <= '0;
            oMaxSteps      <= '0;
            oSlotOverrun   <= 1'b0;
        end else begin
            oQueryDataEn <= 1'b0;
            oQueryData   <= '0;
            oResultValid <= 1'b0;
            oSlotOverrun <= iSlotTick && (state != ST_IDLE);

            case (state)
                ST_IDLE: begin
                    if (iSeedLoadEn) begin
                        seed <= loadSeed;
                    end
                    if (iSlotTick && iEnable) begin
                        state        <= ST_ISSUE;
                        queryCnt     <= '0;
                        stepCnt      <= '0;
                        oQueryDataEn <= 1'b1;
                        // A coincident load is used by the first query.
                        oQueryData   <= iSeedLoadEn ? loadSeed : seed;
                    end
                end

                ST_ISSUE: begin
                    // Preloaded so the first WAIT cycle reads 1.
                    stepCnt <= BW_STEP'(1);
                    state   <= ST_WAIT;
                end

                ST_WAIT: begin
                    if (iQueryEnd) begin
                        oResultValid   <= 1'b1;
                        oResultSeed    <= seed;
                        oResultSteps   <= stepCnt;
                        oResultTimeout <= 1'b0;
                        state          <= ST_REPORT;
                    end else if (stepCnt == BW_STEP'(TIMEOUT)) begin
                        oResultValid   <= 1'b1;
                        oResultSeed    <= seed;
                        oResultSteps   <= BW_STEP'(TIMEOUT);
                        oResultTimeout <= 1'b1;
                        state          <= ST_REPORT;
                    end else begin
                        stepCnt <= stepCnt + BW_STEP'(1);
                    end
                end

                ST_REPORT: begin
                    // Strict compare: a tie keeps the earlier seed.
                    if (!oResultTimeout && (oResultSteps > oMaxSteps)) begin
                        oMaxSeed  <= oResultSeed;
                        oMaxSteps <= oResultSteps;
                    end
                    seed     <= nextSeed;
                    queryCnt <= queryCnt + QCW'(1);
                    if (lastQuery || !iEnable) begin
                        state <= ST_IDLE;
                    end else begin
                        state        <= ST_ISSUE;
                        stepCnt      <= '0;
                        oQueryDataEn <= 1'b1;
                        oQueryData   <= nextSeed;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase

            // Placed after the REPORT update so the clear wins on a collision.
            if (iClrMax) begin
                oMaxSeed  <= '0;
                oMaxSteps <= '0;
            end
        end
    end

endmodule

// File: tb/tb_query_initiator.sv
// tb/tb_query_initiator.sv - directed self-checking bench for query_initiator

module tb_query_initiator;

    logic        iClk = 1'b0;
    logic        iRsn;
    logic        iEnable;
    logic        iSlotTick;
    logic        iSeedLoadEn;
    logic [3:0]  iSeed;
    logic        iClrMax;
    logic        oQueryDataEn;
    logic [3:0]  oQueryData;
    logic        iQueryEnd;
    logic        oResultValid;
    logic [3:0]  oResultSeed;
    logic [15:0] oResultSteps;
    logic        oResultTimeout;
    logic [3:0]  oMaxSeed;
    logic [15:0] oMaxSteps;
    logic        oBusy;
    logic        oSlotOverrun;

    query_initiator #(
        .BW_QUERY_DATA(4),
        .BW_STEP(16),
        .QUERIES_PER_SLOT(4),
        .TIMEOUT(64)
    ) dut (
        .iClk(iClk),
        .iRsn(iRsn),
        .iEnable(iEnable),
        .iSlotTick(iSlotTick),
        .iSeedLoadEn(iSeedLoadEn),
        .iSeed(iSeed),
        .iClrMax(iClrMax),
        .oQueryDataEn(oQueryDataEn),
        .oQueryData(oQueryData),
        .iQueryEnd(iQueryEnd),
        .oResultValid(oResultValid),
        .oResultSeed(oResultSeed),
        .oResultSteps(oResultSteps),
        .oResultTimeout(oResultTimeout),
        .oMaxSeed(oMaxSeed),
        .oMaxSteps(oMaxSteps),
        .oBusy(oBusy),
        .oSlotOverrun(oSlotOverrun)
    );

    always #5 iClk = ~iClk;

    int cyc = 0;
    always @(posedge iClk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Responder latency per query within a burst (0 = never ends).
    int lat [4];
    int respIdx  = 0;
    int respCnt  = 0;
    int respLat  = 0;
    bit respPend = 1'b0;

    // Observed transactions.
    int issSeed  [16];
    int issCyc   [16];
    int resSeed  [16];
    int resSteps [16];
    int resTo    [16];
    int nIssue = 0;
    int nRes   = 0;
    int nOvr   = 0;

    initial begin
        iQueryEnd = 1'b0;
        forever begin
            @(posedge iClk);
            #1;
            iQueryEnd = 1'b0;
            if (respPend) begin
                respCnt++;
                if (respCnt == respLat) begin
                    iQueryEnd = 1'b1;
                    respPend  = 1'b0;
                end
            end
            if (oQueryDataEn) begin
                respLat  = lat[respIdx % 4];
                respIdx++;
                respPend = (respLat != 0);
                respCnt  = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge iClk);
            if (oQueryDataEn && nIssue < 16) begin
                issSeed[nIssue] = int'(oQueryData);
                issCyc[nIssue]  = cyc;
                nIssue++;
            end
            if (oResultValid && nRes < 16) begin
                resSeed[nRes]  = int'(oResultSeed);
                resSteps[nRes] = int'(oResultSteps);
                resTo[nRes]    = int'(oResultTimeout);
                nRes++;
            end
            if (oSlotOverrun) nOvr++;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge iClk);
        #1;
    endtask

    task automatic tick();
        iSlotTick = 1'b1;
        step();
        iSlotTick = 1'b0;
    endtask

    task automatic clearLog();
        nIssue  = 0;
        nRes    = 0;
        nOvr    = 0;
        respIdx = 0;
    endtask

    task automatic setLat(input int a, input int b, input int c, input int d);
        lat[0] = a; lat[1] = b; lat[2] = c; lat[3] = d;
    endtask

    task automatic loadSeed(input int s);
        iSeedLoadEn = 1'b1;
        iSeed       = 4'(s);
        step();
        iSeedLoadEn = 1'b0;
        step();
    endtask

    task automatic pulseClrMax();
        iClrMax = 1'b1;
        step();
        iClrMax = 1'b0;
    endtask

    task automatic waitIdle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!oBusy) break;
            step();
        end
        check(tag, int'(oBusy), 0);
        step();
    endtask

    initial begin
        iRsn        = 1'b1;
        iEnable     = 1'b0;
        iSlotTick   = 1'b0;
        iSeedLoadEn = 1'b0;
        iSeed       = 4'd0;
        iClrMax     = 1'b0;
        setLat(3, 3, 3, 3);

        // Reset state
        step(); step(); step();
        check("rst_busy", int'(oBusy), 0);
        check("rst_qen", int'(oQueryDataEn), 0);
        check("rst_maxsteps", int'(oMaxSteps), 0);
        check("rst_resvalid", int'(oResultValid), 0);
        iRsn    = 1'b0;
        iEnable = 1'b1;
        step();

        // Burst of 4, latency 3, from seed 5
        loadSeed(5);
        clearLog();
        tick();
        waitIdle("t1_idle", 100);
        check("t1_nissue", nIssue, 4);
        check("t1_nres", nRes, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t1_seed%0d", i), issSeed[i], 5 + i);
            check($sformatf("t1_steps%0d", i), resSteps[i], 3);
            check($sformatf("t1_to%0d", i), resTo[i], 0);
        end
        for (int i = 1; i < 4; i++) begin
            check($sformatf("t1_space%0d", i), issCyc[i] - issCyc[i-1], 5);
        end
        check("t1_maxseed", int'(oMaxSeed), 5);
        check("t1_maxsteps", int'(oMaxSteps), 3);
        check("t1_holdseed", int'(oResultSeed), 8);

        // Latencies 2,7,7,4 for seeds 1..4: tie keeps seed 2
        pulseClrMax();
        check("t2_clr", int'(oMaxSteps), 0);
        loadSeed(1);
        setLat(2, 7, 7, 4);
        clearLog();
        tick();
        waitIdle("t2_idle", 100);
        check("t2_steps1", resSteps[1], 7);
        check("t2_steps3", resSteps[3], 4);
        check("t2_maxseed", int'(oMaxSeed), 2);
        check("t2_maxsteps", int'(oMaxSteps), 7);

        // Responder never ends: every query times out at 64
        pulseClrMax();
        setLat(0, 0, 0, 0);
        clearLog();
        tick();
        waitIdle("t3_idle", 400);
        check("t3_nres", nRes, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t3_steps%0d", i), resSteps[i], 64);
            check($sformatf("t3_to%0d", i), resTo[i], 1);
        end
        check("t3_seed0", resSeed[0], 5);
        check("t3_maxseed", int'(oMaxSeed), 0);
        check("t3_maxsteps", int'(oMaxSteps), 0);

        // Seed wrap skips zero
        loadSeed(15);
        setLat(1, 1, 1, 1);
        clearLog();
        tick();
        waitIdle("t4_idle", 100);
        check("t4_seed0", issSeed[0], 15);
        check("t4_seed1", issSeed[1], 1);
        check("t4_seed3", issSeed[3], 3);
        check("t4_steps0", resSteps[0], 1);

        // Zero seed loaded together with the tick issues seed 1
        clearLog();
        iSeedLoadEn = 1'b1;
        iSeed       = 4'd0;
        iSlotTick   = 1'b1;
        step();
        iSeedLoadEn = 1'b0;
        iSlotTick   = 1'b0;
        waitIdle("t4b_idle", 100);
        check("t4b_seed0", issSeed[0], 1);
        check("t4b_seed3", issSeed[3], 4);

        // Overrun tick during WAIT: one pulse, burst still 4 queries
        setLat(3, 3, 3, 3);
        clearLog();
        tick();
        step();
        tick();
        waitIdle("t5_idle", 100);
        check("t5_novr", nOvr, 1);
        check("t5_nres", nRes, 4);
        check("t5_seed0", issSeed[0], 5);

        // Enable dropped during the 2nd query: two results then IDLE
        clearLog();
        tick();
        for (int i = 0; i < 50; i++) begin
            if (nIssue >= 2) break;
            step();
        end
        check("t5b_reach2", nIssue, 2);
        iEnable = 1'b0;
        waitIdle("t5b_idle", 100);
        check("t5b_nres", nRes, 2);
        check("t5b_nissue", nIssue, 2);
        check("t5b_seed1", resSeed[1], 10);
        iEnable = 1'b1;
        check("t5b_maxpre", int'(oMaxSteps), 3);

        // Reset during WAIT aborts the burst, restart at seed 1
        setLat(50, 50, 50, 50);
        clearLog();
        tick();
        step(); step(); step();
        check("t6_inwait", int'(oBusy), 1);
        iRsn = 1'b1;
        step();
        iRsn = 1'b0;
        respPend = 1'b0;
        check("t6_busy", int'(oBusy), 0);
        check("t6_maxsteps", int'(oMaxSteps), 0);
        check("t6_maxseed", int'(oMaxSeed), 0);
        check("t6_resseed", int'(oResultSeed), 0);
        check("t6_ressteps", int'(oResultSteps), 0);
        check("t6_qen", int'(oQueryDataEn), 0);
        check("t6_ovr", int'(oSlotOverrun), 0);
        step();
        check("t6_nores", nRes, 0);
        setLat(2, 2, 2, 2);
        clearLog();
        tick();
        waitIdle("t6_idle", 100);
        check("t6_seed0", issSeed[0], 1);
        check("t6_steps0", resSteps[0], 2);
        check("t6_nres2", nRes, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
